alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Sequential execute unit that consumes the 4-bit ALUControl encoding produced by the ALU decoder and computes the result.
- Logical, arithmetic and compare ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle.
- Sits between decode and writeback in the multi-cycle datapath, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- alu_control  input  4  op code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt, 0110 sltu, 0111 xor, 1000 srl, 1001 sra
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B; shifts use src_b[SHW-1:0] only
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result
- illegal  output  1  alu_control was 1010..1111

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0; internal shift counter and operand registers cleared. Reset during SHIFT abandons the operation and produces no output.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0.
  - Accept on in_valid&&in_ready; latch alu_control, src_a, src_b.
  - Non-shift op: compute and register result -> DONE. Latency 1 cycle (out_valid asserts the cycle after accept).
  - Shift op with shamt=0: result=src_a -> DONE, latency 1.
  - Shift op with shamt>0: load acc=src_a, cnt=shamt -> SHIFT.
- SHIFT: in_ready=0.
  - Each cycle: acc shifts one position (sll: left, zero fill; srl: right, zero fill; sra: right, replicate acc[WIDTH-1]); cnt decrements.
  - When cnt reaches 1 on this cycle's update: result=shifted acc -> DONE.
  - Total latency 1+shamt cycles; max 1+(WIDTH-1).
- DONE: out_valid=1; result, zero, illegal held stable; in_ready=0.
  - out_ready=1 -> IDLE next cycle (out_valid drops).
  - Stalls indefinitely while out_ready=0.
  - Throughput: at most one op per 2 cycles.
- Arithmetic: add/sub modulo 2^WIDTH, carry/overflow discarded.
  - slt: signed compare src_a<src_b -> result 1, else 0, zero-extended.
  - sltu: unsigned compare.
- Illegal codes 1010..1111: result=0, zero=1, illegal=1, latency 1. illegal is 0 for all legal ops.
- Inputs are sampled only at accept; changes while busy are ignored.
- in_valid while not in_ready: no effect; the request must be held by the producer.

Optional Feature:
- Macro ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally at accept and go straight to DONE. Every op, including shifts of any amount, has latency 1. The SHIFT state is unreachable/absent.
- Undefined: iterative shifting as described above, latency 1+shamt.

Test Plan:
- After reset, add a=0x0000_0005, b=0x0000_0003 -> out_valid the cycle after accept, result=0x0000_0008, zero=0, illegal=0.
- sub a=7, b=7 -> result=0, zero=1. slt a=0xFFFF_FFFF, b=1 -> result=1. sltu with the same operands -> result=0.
- sra a=0x8000_0000, b=0x0000_0024 (shamt=4) -> result=0xF800_0000 after 5 cycles (1 with ALU_EXEC_BARREL_SHIFT_EN). srl with the same operands -> 0x0800_0000. sll a=1, shamt=0 -> result=1 after 1 cycle.
- Result backpressure: complete xor a=0xFF00_FF00, b=0x0F0F_0F0F, hold out_ready=0 for 10 cycles -> out_valid and result=0xF00F_F00F stable, in_ready=0. Raise out_ready -> IDLE next cycle.
- alu_control=1100, a=0x1234, b=0x5678 -> result=0, zero=1, illegal=1. A following legal or op -> illegal=0.
- Start sll with shamt=31, assert reset on the 3rd SHIFT cycle -> all outputs 0 and in_ready=1 immediately. A new add request is then accepted and completes normally.

Source files
------------

// File: rtl/alu_exec_seq_if.sv
// Request/result handshake bundle for the sequential execute unit.
// The master drives requests and accepts results; the slave is the unit.
interface alu_exec_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_seq.sv
// Sequential ALU execute unit: one-cycle logic/arith, iterative shifts.
// ALU_EXEC_BARREL_SHIFT_EN: shifts finish in one cycle via a barrel shifter.
module alu_exec_seq #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_exec_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             is_illegal;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc_next;

    function automatic logic [WIDTH-1:0] alu_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, a < b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bit position per call; sra replicates the current sign bit.
    function automatic logic [WIDTH-1:0] shift1(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    function automatic logic [WIDTH-1:0] barrel(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [SHW-1:0]   s
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = a << s;
            OP_SRL:  r = a >> s;
            default: r = $signed(a) >>> s;
        endcase
        return r;
    endfunction
`endif

    assign shamt      = bus.src_b[SHW-1:0];
    assign is_shift   = (bus.alu_control == OP_SLL) ||
                        (bus.alu_control == OP_SRL) ||
                        (bus.alu_control == OP_SRA);
    assign is_illegal = bus.alu_control[3] &
                        (bus.alu_control[2] | bus.alu_control[1]);
    assign acc_next   = shift1(op_q, acc_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        res       = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d      = bus.alu_control;
                    illegal_d = is_illegal;
                    state_d   = DONE;
                    if (is_shift) begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
                        res = barrel(bus.alu_control, bus.src_a, shamt);
`else
                        res = bus.src_a;
                        if (shamt != '0) begin
                            acc_d   = bus.src_a;
                            cnt_d   = shamt;
                            state_d = SHIFT;
                        end
`endif
                    end else begin
                        res = alu_op(bus.alu_control, bus.src_a, bus.src_b);
                    end
                    if (state_d == DONE) begin
                        result_d = res;
                        zero_d   = (res == '0);
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: scoreboard of expected results,
// one task per scenario.
module tb_alu_exec_seq;
    localparam int W = 32;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_seq_if #(.WIDTH(W)) bus ();
    alu_exec_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic bit is_sh(input logic [3:0] op);
        return (op == 4'h4) || (op == 4'h8) || (op == 4'h9);
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        if (!BARREL && is_sh(op)) return 1 + int'(s);
        return 1;
    endfunction

    // Reference model; shifts done bit by bit, sub via two's complement.
    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a + ~b + 32'd1;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h5: r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
            4'h6: r = {31'h0, a < b};
            4'h7: r = a ^ b;
            4'h4, 4'h8, 4'h9: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) begin
                    if (op == 4'h4)      r = {r[30:0], 1'b0};
                    else if (op == 4'h8) r = {1'b0, r[31:1]};
                    else                 r = {r[31], r[31:1]};
                end
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r);
        exp_t e;
        int   n;
        e.res = r;
        e.z   = (r == 32'h0);
        e.ill = (op >= 4'hA);
        e.lat = exp_lat(op, b);
        exp_q.push_back(e);
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.in_valid    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.result !== 32'h0) begin
            failures++; $display("FAIL rst_result got=%h exp=0", bus.result);
        end
        if (bus.zero !== 1'b0) begin
            failures++; $display("FAIL rst_zero got=%b exp=0", bus.zero);
        end
        if (bus.illegal !== 1'b0) begin
            failures++; $display("FAIL rst_illegal got=%b exp=0", bus.illegal);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        vec_t v[6];
        exp_t e;
        int   lat;
        v[0] = '{4'h0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
        v[1] = '{4'h1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000};
        v[2] = '{4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        v[3] = '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        v[4] = '{4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        v[5] = '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].r);
            wait_out(lat);
            e = exp_q.pop_front();
            checks += 4;
            if (bus.result !== e.res) begin
                failures++;
                $display("FAIL alu_result[%0d] got=%h exp=%h", i, bus.result, e.res);
            end
            if (bus.zero !== e.z) begin
                failures++; $display("FAIL alu_zero[%0d] got=%b exp=%b", i, bus.zero, e.z);
            end
            if (bus.illegal !== e.ill) begin
                failures++;
                $display("FAIL alu_illegal[%0d] got=%b exp=%b", i, bus.illegal, e.ill);
            end
            if (lat != e.lat) begin
                failures++; $display("FAIL alu_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_shift();
        vec_t v[6];
        exp_t e;
        int   lat;
        v[0] = '{4'h9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
        v[1] = '{4'h8, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        v[2] = '{4'h4, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        v[3] = '{4'h4, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        v[4] = '{4'h9, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000};
        v[5] = '{4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'h7FFF_FFFF};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].r);
            wait_out(lat);
            e = exp_q.pop_front();
            checks += 4;
            if (bus.result !== e.res) begin
                failures++;
                $display("FAIL sh_result[%0d] got=%h exp=%h", i, bus.result, e.res);
            end
            if (bus.zero !== e.z) begin
                failures++; $display("FAIL sh_zero[%0d] got=%b exp=%b", i, bus.zero, e.z);
            end
            if (bus.illegal !== e.ill) begin
                failures++;
                $display("FAIL sh_illegal[%0d] got=%b exp=%b", i, bus.illegal, e.ill);
            end
            if (lat != e.lat) begin
                failures++; $display("FAIL sh_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        issue(4'h7, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            checks += 3;
            if (bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, bus.out_valid);
            end
            if (bus.result !== e.res) begin
                failures++;
                $display("FAIL bp_result[%0d] got=%h exp=%h", c, bus.result, e.res);
            end
            if (bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_illegal();
        vec_t v[3];
        exp_t e;
        int   lat;
        v[0] = '{4'hC, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000};
        v[1] = '{4'h3, 32'h0000_1234, 32'h0000_5678, 32'h0000_567C};
        v[2] = '{4'hA, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].r);
            wait_out(lat);
            e = exp_q.pop_front();
            checks += 4;
            if (bus.result !== e.res) begin
                failures++;
                $display("FAIL ill_result[%0d] got=%h exp=%h", i, bus.result, e.res);
            end
            if (bus.zero !== e.z) begin
                failures++; $display("FAIL ill_zero[%0d] got=%b exp=%b", i, bus.zero, e.z);
            end
            if (bus.illegal !== e.ill) begin
                failures++;
                $display("FAIL ill_flag[%0d] got=%b exp=%b", i, bus.illegal, e.ill);
            end
            if (lat != e.lat) begin
                failures++; $display("FAIL ill_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   lat;
        issue(4'h0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
        wait_out(lat);
        void'(exp_q.pop_front());
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(4'h4, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks += 4;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.result !== 32'h0) begin
            failures++; $display("FAIL mid_rst_result got=%h exp=0", bus.result);
        end
        if ({bus.zero, bus.illegal} !== 2'b00) begin
            failures++;
            $display("FAIL mid_rst_flags got=%b%b exp=00", bus.zero, bus.illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(4'h0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        wait_out(lat);
        e = exp_q.pop_front();
        checks += 3;
        if (bus.result !== e.res) begin
            failures++; $display("FAIL post_rst_result got=%h exp=%h", bus.result, e.res);
        end
        if (bus.zero !== e.z) begin
            failures++; $display("FAIL post_rst_zero got=%b exp=%b", bus.zero, e.z);
        end
        if (lat != e.lat) begin
            failures++; $display("FAIL post_rst_latency got=%0d exp=%0d", lat, e.lat);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [3:0]  op;
                    logic [31:0] a;
                    logic [31:0] b;
                    op = 4'($urandom_range(0, 15));
                    a  = $urandom;
                    b  = (i % 3 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    issue(op, a, b, model(op, a, b));
                end
            end
            begin
                for (int j = 0; j < N; j++) begin
                    exp_t e;
                    int   lat;
                    wait_out(lat);
                    e = exp_q.pop_front();
                    checks += 3;
                    if (bus.result !== e.res) begin
                        failures++;
                        $display("FAIL b2b_result[%0d] got=%h exp=%h", j, bus.result, e.res);
                    end
                    if (bus.zero !== e.z) begin
                        failures++;
                        $display("FAIL b2b_zero[%0d] got=%b exp=%b", j, bus.zero, e.z);
                    end
                    if (bus.illegal !== e.ill) begin
                        failures++;
                        $display("FAIL b2b_illegal[%0d] got=%b exp=%b", j, bus.illegal, e.ill);
                    end
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'h0;
        bus.src_a       = 32'h0;
        bus.src_b       = 32'h0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_alu();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
